// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared constants and helpers for the Hamming(7,4) stream encoder.
//   CW_W              : width of one Hamming(7,4) codeword (7)
//   P2/P1/P0_MASK     : data-bit selections {d3,d2,d1,d0} feeding each parity
//   hamming74_code()  : nibble -> 7-bit codeword {d3,d2,d1,d0,p2,p1,p0}
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam int CW_W = 7;

    // Masks apply to the nibble ordered {d3,d2,d1,d0}.
    localparam logic [3:0] P2_MASK = 4'b1110;   // d3^d2^d1
    localparam logic [3:0] P1_MASK = 4'b1101;   // d3^d2^d0
    localparam logic [3:0] P0_MASK = 4'b1011;   // d3^d1^d0

    function automatic logic [CW_W-1:0] hamming74_code(input logic [3:0] nib);
        return {nib, ^(nib & P2_MASK), ^(nib & P1_MASK), ^(nib & P0_MASK)};
    endfunction

endpackage

// File: rtl/hamming74_cw.sv
// -----------------------------------------------------------------------------
// hamming74_cw
// Combinational Hamming(7,4) codeword generator for a single nibble.
// Ports:
//   nib_i  in  4  data nibble, bit 3 = d3 (MSB)
//   code_o out 7  codeword {d3,d2,d1,d0,p2,p1,p0}
//   par_o  out 1  even overall parity of code_o (XOR of all 7 bits)
// -----------------------------------------------------------------------------
module hamming74_cw
    import hamming_pkg::*;
(
    input  logic [3:0]      nib_i,
    output logic [CW_W-1:0] code_o,
    output logic            par_o
);

    always_comb begin
        code_o = hamming74_code(nib_i);
        par_o  = ^code_o;
    end

endmodule

// File: rtl/hamming_stream_enc.sv
// -----------------------------------------------------------------------------
// hamming_stream_enc
// Streaming Hamming(7,4) encoder with a DEPTH-entry output FIFO and a counter
// of accepted words. Each 4*NIBBLES-bit input beat is encoded nibble by nibble
// and packed MSB-first (7 bits per nibble) into an 8*NIBBLES-bit word; the low
// NIBBLES bits are pad bits.
//
// Build option: define HAMMING_SECDED_EN to place the overall parity of code i
// in pad bit (NIBBLES-1-i) (extended SECDED codewords). Undefined: pads are 0.
//
// Ports:
//   clk       in   1            clock, rising edge
//   rst       in   1            synchronous active-high reset
//   clr       in   1            synchronous flush of FIFO and counter
//   in_data   in   4*NIBBLES    data beat, nibble 0 in the MSBs
//   in_valid  in   1            in_data valid
//   in_ready  out  1            encoder can accept a beat
//   out_data  out  8*NIBBLES    registered FIFO head
//   out_valid out  1            out_data valid
//   out_ready in   1            downstream accepts out_data
//   level     out  clog2(D)+1   FIFO occupancy
//   word_cnt  out  WCNT_W       words accepted since reset/clr (wraps)
// -----------------------------------------------------------------------------
module hamming_stream_enc
    import hamming_pkg::*;
#(
    parameter int NIBBLES = 2,
    parameter int DEPTH   = 4,
    parameter int WCNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [4*NIBBLES-1:0]       in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [8*NIBBLES-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [WCNT_W-1:0]          word_cnt
);

    localparam int IN_W  = 4 * NIBBLES;
    localparam int OUT_W = 8 * NIBBLES;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

`ifdef HAMMING_SECDED_EN
    localparam logic SECDED_EN = 1'b1;
`else
    localparam logic SECDED_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- encode
    logic [CW_W-1:0] code  [NIBBLES];
    logic            par   [NIBBLES];
    wire  [OUT_W-1:0] enc_word;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            hamming74_cw u_cw (
                .nib_i  (in_data[IN_W-1-4*gi -: 4]),
                .code_o (code[gi]),
                .par_o  (par[gi])
            );
            assign enc_word[OUT_W-1-CW_W*gi -: CW_W] = code[gi];
            // Pad bits sit below all codewords, in reverse nibble order.
            assign enc_word[NIBBLES-1-gi] = par[gi] & SECDED_EN;
        end
    endgenerate

    // ------------------------------------------------------------------ FIFO
    logic [OUT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [OUT_W-1:0]  head_q, head_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic              push, pop;

    // in_ready does not look at out_ready: a full FIFO refuses a beat even
    // if a pop happens in the same cycle.
    assign in_ready  = !rst && (level_q < LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready && !clr;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        cnt_d    = cnt_q + WCNT_W'(push);
        // The head register is preloaded with whatever will be at the read
        // pointer after this edge. If the FIFO drains to empty and the new
        // beat lands in that very slot, the memory is not written yet, so
        // take the freshly encoded word directly.
        if (level_d == '0) begin
            head_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = enc_word;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array carries no reset so it can map onto RAM/LUT-RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    assign out_data = head_q;
    assign level    = level_q;
    assign word_cnt = cnt_q;

endmodule
